// File: rtl/serial_to_parallel_if.sv
// Parallel output port of the deserializer: assembled word plus valid/ready handshake.
interface serial_to_parallel_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output parallel_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  parallel_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer: start strobe then DATA_WIDTH serial bits, assembled into a word
// held in a one-entry valid/ready holding register with sticky overrun/abort flags.
module serial_to_parallel #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 serial_in,
  serial_to_parallel_if.master word_bus,
  output logic                 busy,
  output logic                 overrun,
  output logic                 abort,
  input  logic                 err_clr
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  abort_q, abort_d;

  logic                  last_bit;
  logic                  drain;
  logic [CNT_W-1:0]      bit_pos;
  logic [DATA_WIDTH-1:0] word_c;

  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign drain    = valid_q && word_bus.out_ready;
  assign bit_pos  = LSB_FIRST ? cnt_q : (CNT_W'(DATA_WIDTH - 1) - cnt_q);

  // Shift register with the bit sampled this cycle merged in (includes the final bit).
  always_comb begin
    word_c          = shift_q;
    word_c[bit_pos] = serial_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a start during SHIFT restarts the frame in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (!start && last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag next values; flag set conditions override err_clr.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    abort_d   = abort_q;

    if (err_clr) begin
      overrun_d = 1'b0;
      abort_d   = 1'b0;
    end
    if (drain) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          shift_d = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (last_bit) begin
          shift_d = '0;
          cnt_d   = '0;
          if (!valid_q || drain) begin
            data_d  = word_c;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          shift_d = word_c;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
    end
  end

  assign word_bus.parallel_out = data_q;
  assign word_bus.out_valid    = valid_q;
  assign busy                  = (state_q == SHIFT);
  assign overrun               = overrun_q;
  assign abort                 = abort_q;

endmodule
